// File: rtl/shift_rotate_unit_if.sv
// Request/response bundle between the control unit and the shift/rotate unit.
// The control unit is the master; the execution unit is the slave.
interface shift_rotate_unit_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH);

    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] operand;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, operand, count,
        input  result, carry, zero, busy, done
    );

    modport slave (
        input  start, mode, operand, count,
        output result, carry, zero, busy, done
    );
endinterface

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: latches operand and count on start, shifts
// up to STEP bits per cycle, then presents result/carry/zero with a done pulse.
module shift_rotate_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                clk,
    input  logic                clr,
    shift_rotate_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        M_SHR  = 3'b000,
        M_SHRA = 3'b001,
        M_SHL  = 3'b010,
        M_ROR  = 3'b011,
        M_ROL  = 3'b100
    } mode_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_mode;
    logic [CW-1:0]    r_remaining;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic [CW-1:0]    w_step;
    logic [CW-1:0]    w_inv;
    logic [WIDTH-1:0] w_next;
    logic             w_carry;
    logic             w_last;
    logic             w_pass;

    // w_inv = WIDTH - s, valid whenever s >= 1 (always true while in RUN)
    always_comb begin
        w_step = (r_remaining < CW'(STEP)) ? r_remaining : CW'(STEP);
        w_inv  = '0 - w_step;
        w_last = (r_remaining == w_step);
        w_pass = (bus.count == '0) || (bus.mode > M_ROL);
    end

    always_comb begin
        w_next  = r_work;
        w_carry = 1'b0;
        case (r_mode)
            M_SHR: begin
                w_next  = r_work >> w_step;
                w_carry = r_work[w_step - 1'b1];
            end
            M_SHRA: begin
                w_next  = WIDTH'($signed(r_work) >>> w_step);
                w_carry = r_work[w_step - 1'b1];
            end
            M_SHL: begin
                w_next  = r_work << w_step;
                w_carry = r_work[w_inv];
            end
            M_ROR: begin
                w_next  = (r_work >> w_step) | (r_work << w_inv);
                w_carry = w_next[WIDTH-1];
            end
            M_ROL: begin
                w_next  = (r_work << w_step) | (r_work >> w_inv);
                w_carry = w_next[0];
            end
            default: begin
                w_next  = r_work;
                w_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_mode      <= '0;
            r_remaining <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_work      <= bus.operand;
                        r_mode      <= bus.mode;
                        r_remaining <= bus.count;
                        if (w_pass) begin
                            r_result <= bus.operand;
                            r_carry  <= 1'b0;
                            r_zero   <= (bus.operand == '0);
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_work      <= w_next;
                    r_remaining <= r_remaining - w_step;
                    if (w_last) begin
                        r_result <= w_next;
                        r_carry  <= w_carry;
                        r_zero   <= (w_next == '0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.carry  = r_carry;
    assign bus.zero   = r_zero;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench: two instances (STEP=1 and STEP=4) against an arithmetic
// reference model, covering directed cases, handshake, reset and random ops.
module tb_shift_rotate_unit;
    logic clk;
    logic clr;
    int   total;
    int   bad;

    logic [31:0] p1_res, p4_res;
    logic        p1_car, p4_car, p1_zero, p4_zero;

    shift_rotate_unit_if #(.WIDTH(32)) bus1 ();
    shift_rotate_unit_if #(.WIDTH(32)) bus4 ();

    shift_rotate_unit #(.WIDTH(32), .STEP(1)) u_dut1 (.clk(clk), .clr(clr), .bus(bus1));
    shift_rotate_unit #(.WIDTH(32), .STEP(4)) u_dut4 (.clk(clk), .clr(clr), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: result and carry straight from the operation definitions.
    function automatic logic [32:0] model(input logic [2:0] md, input logic [31:0] op,
                                          input logic [4:0] cnt);
        int          n;
        logic [63:0] wide;
        logic [31:0] res;
        logic        car;
        n = int'(cnt);
        if (n == 0 || md > 3'd4) return {1'b0, op};
        case (md)
            3'd0: begin res = op >> n; car = op[n-1]; end
            3'd1: begin wide = {{32{op[31]}}, op}; wide = wide >> n; res = wide[31:0]; car = op[n-1]; end
            3'd2: begin res = op << n; car = op[32-n]; end
            3'd3: begin res = (op >> n) | (op << (32 - n)); car = res[31]; end
            default: begin res = (op << n) | (op >> (32 - n)); car = res[0]; end
        endcase
        return {car, res};
    endfunction

    function automatic int cycles(input logic [2:0] md, input logic [4:0] cnt, input int step);
        if (cnt == 0 || md > 3'd4) return 0;
        return (int'(cnt) + step - 1) / step;
    endfunction

    task automatic check_cycle(input string pfx, input int c, input int m,
                               input logic busy, input logic done, input logic [31:0] res,
                               input logic car, input logic zr,
                               input logic [31:0] eres, input logic ecar,
                               input logic [31:0] pres, input logic pcar, input logic pzero);
        check_eq($sformatf("%s_busy_c%0d", pfx, c), {31'd0, busy}, {31'd0, (c < m)});
        check_eq($sformatf("%s_done_c%0d", pfx, c), {31'd0, done}, {31'd0, (c == m)});
        if (c < m) begin
            check_eq($sformatf("%s_hold_res_c%0d", pfx, c), res, pres);
            check_eq($sformatf("%s_hold_car_c%0d", pfx, c), {31'd0, car}, {31'd0, pcar});
            check_eq($sformatf("%s_hold_zero_c%0d", pfx, c), {31'd0, zr}, {31'd0, pzero});
        end else begin
            check_eq($sformatf("%s_res_c%0d", pfx, c), res, eres);
            check_eq($sformatf("%s_car_c%0d", pfx, c), {31'd0, car}, {31'd0, ecar});
            check_eq($sformatf("%s_zero_c%0d", pfx, c), {31'd0, zr}, {31'd0, (eres == 32'd0)});
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] md, input logic [31:0] op,
                          input logic [4:0] cnt);
        logic [32:0] e;
        int          m1, m4, last;
        e  = model(md, op, cnt);
        m1 = cycles(md, cnt, 1);
        m4 = cycles(md, cnt, 4);
        last = (m1 > m4 ? m1 : m4) + 1;
        @(negedge clk);
        bus1.start = 1'b1; bus1.mode = md; bus1.operand = op; bus1.count = cnt;
        bus4.start = 1'b1; bus4.mode = md; bus4.operand = op; bus4.count = cnt;
        @(posedge clk);
        #1;
        bus1.start = 1'b0; bus4.start = 1'b0;
        bus1.operand = $urandom; bus1.count = 5'($urandom); bus1.mode = 3'($urandom);
        bus4.operand = $urandom; bus4.count = 5'($urandom); bus4.mode = 3'($urandom);
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            check_cycle({name, "_s1"}, c, m1, bus1.busy, bus1.done, bus1.result, bus1.carry,
                        bus1.zero, e[31:0], e[32], p1_res, p1_car, p1_zero);
            check_cycle({name, "_s4"}, c, m4, bus4.busy, bus4.done, bus4.result, bus4.carry,
                        bus4.zero, e[31:0], e[32], p4_res, p4_car, p4_zero);
        end
        p1_res = e[31:0]; p1_car = e[32]; p1_zero = (e[31:0] == 32'd0);
        p4_res = p1_res;  p4_car = p1_car; p4_zero = p1_zero;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_s1_res"}, bus1.result, 32'd0);
        check_eq({tag, "_s1_flags"}, {28'd0, bus1.carry, bus1.zero, bus1.busy, bus1.done}, 32'd0);
        check_eq({tag, "_s4_res"}, bus4.result, 32'd0);
        check_eq({tag, "_s4_flags"}, {28'd0, bus4.carry, bus4.zero, bus4.busy, bus4.done}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [32:0] e2;
        total = 0;
        bad   = 0;
        bus1.start = 1'b0; bus1.mode = '0; bus1.operand = '0; bus1.count = '0;
        bus4.start = 1'b0; bus4.mode = '0; bus4.operand = '0; bus4.count = '0;
        p1_res = '0; p1_car = 1'b0; p1_zero = 1'b0;
        p4_res = '0; p4_car = 1'b0; p4_zero = 1'b0;

        clr = 1'b1;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;

        run_op("rol_c44", 3'b100, 32'hC440_0000, 5'd5);
        check_eq("rol_c44_value", p1_res, 32'h8800_0018);
        run_op("shra", 3'b001, 32'h8000_0010, 5'd5);
        run_op("shr", 3'b000, 32'h8000_0010, 5'd5);
        run_op("shl31", 3'b010, 32'h0000_0001, 5'd31);
        run_op("shl1", 3'b010, 32'h8000_0000, 5'd1);
        run_op("ror_c0", 3'b011, 32'h1234_5678, 5'd0);
        run_op("pass110", 3'b110, 32'h1234_5678, 5'd7);
        run_op("pass_zero", 3'b111, 32'h0000_0000, 5'd9);

        // Reset between edges k+3 and k+4 of a long ROL.
        @(negedge clk);
        bus1.start = 1'b1; bus1.mode = 3'b100; bus1.operand = 32'h0000_FFFF; bus1.count = 5'd20;
        bus4.start = 1'b1; bus4.mode = 3'b100; bus4.operand = 32'h0000_FFFF; bus4.count = 5'd20;
        @(posedge clk);
        #1;
        bus1.start = 1'b0; bus4.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        check_all_zero("midrun_clr");
        @(negedge clk);
        clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_all_zero($sformatf("after_clr_c%0d", c));
        end
        p1_res = '0; p1_car = 1'b0; p1_zero = 1'b0;
        p4_res = '0; p4_car = 1'b0; p4_zero = 1'b0;
        run_op("ror1", 3'b011, 32'h0000_0001, 5'd1);

        // start held high on the STEP=1 unit: inputs change during RUN.
        r  = $urandom;
        e2 = model(3'b100, r, 5'd2);
        @(negedge clk);
        bus1.start = 1'b1; bus1.mode = 3'b100; bus1.operand = 32'h0000_0003; bus1.count = 5'd2;
        @(posedge clk);
        #1;
        bus1.operand = r;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            check_eq($sformatf("held_busy_c%0d", c), {31'd0, bus1.busy},
                     {31'd0, (c == 0 || c == 1 || c == 4 || c == 5)});
            check_eq($sformatf("held_done_c%0d", c), {31'd0, bus1.done},
                     {31'd0, (c == 2 || c == 6)});
            if (c >= 2 && c < 6) check_eq($sformatf("held_res1_c%0d", c), bus1.result, 32'h0000_000C);
            if (c >= 6) begin
                check_eq($sformatf("held_res2_c%0d", c), bus1.result, e2[31:0]);
                check_eq($sformatf("held_car2_c%0d", c), {31'd0, bus1.carry}, {31'd0, e2[32]});
            end
            if (c == 6) bus1.start = 1'b0;
        end
        p1_res = e2[31:0]; p1_car = e2[32]; p1_zero = (e2[31:0] == 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 31)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_rotate_unit.md
# shift_rotate_unit

Multi-cycle, parametrised shift/rotate execution unit for the bus-based CPU datapath. It generalises the single-cycle rotate path to logical, arithmetic and rotate operations in both directions. Width and bits-per-cycle are configurable. The unit latches an operand and a count on `start`, iterates, and presents a registered result with carry/zero flags and a one-cycle `done` pulse for the control unit to gate into Z.

## Interface
- `WIDTH`, 32, datapath width; power of two, ≥ 8.
- `STEP`, 1, bits shifted per iteration cycle; power of two, 1 ≤ STEP ≤ WIDTH/2.
- `CW` (localparam) = $clog2(WIDTH), count width.

- `clk`  in  1  clock; all state changes on rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101–111 pass.
- `operand`  in  WIDTH  value to shift, latched on accepted start.
- `count`  in  CW  shift amount; inherently 0..WIDTH-1, latched on accepted start.
- `result`  out  WIDTH  registered result, held until the next completion.
- `carry`  out  1  last bit shifted/rotated out, registered with result.
- `zero`  out  1  result == 0, registered with result.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse, high in DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If `start` = 1, latch operand into the working register, latch mode, and latch `count` into `remaining`.
  - If count = 0 or mode is 101–111, go to DONE and load `result` = operand and `carry` = 0 at the same edge.
  - Otherwise go to RUN.
- RUN, each edge:
  - Shift the working register by s = min(STEP, remaining), and set `remaining` -= s.
  - Track carry as the last bit leaving the word: SHR/SHRA take bit s-1 of the pre-shift value; SHL takes bit WIDTH-s.
  - For ROR, carry is the new MSB; for ROL, carry is the new LSB.
  - When `remaining` reaches 0 on this edge, load `result`, `carry` and `zero` from the final working value and go to DONE.
- Shift fill rules:
  - SHR fills with 0.
  - SHRA fills with the sign bit of the working value.
  - SHL fills with 0.
  - ROR and ROL wrap bits around.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE unconditionally. `start` in DONE is ignored.
- `start` in RUN is ignored; operand, count and mode changes during RUN have no effect.
- `result`, `carry` and `zero` change only on entry to DONE or on reset. During RUN they hold the previous operation's values.
- Reset (`clr`), effective immediately regardless of clock:
  - State goes to IDLE.
  - `result`, `carry`, `zero`, `busy` and `done` are all 0.
  - Working register and `remaining` are cleared.
  - Reset mid-RUN abandons the operation with no `done` pulse.

## Timing
- Let n = latched count and m = ceil(n/STEP).
- `start` is accepted at edge k. `busy` is high from edge k to edge k+m.
- `result` is valid and `done` is high from edge k+m to edge k+m+1.
- n = 0 or pass mode: `done` is high from edge k to k+1, with `busy` never high.
- Earliest next accepted start is at edge k+m+2 (from IDLE); issue rate is one operation per m+2 cycles.
- Outputs are glitch-free registered values; no combinational path exists from inputs to outputs.

## Test plan
- ROL, WIDTH=32, STEP=1: operand 0xC4400000, count 5, start at edge k:
  - `busy` for 5 cycles, then `done` pulse at edge k+5.
  - result 0x88000018, carry 0, zero 0.
  - Repeat with STEP=4: identical result, `done` at edge k+2.
- SHRA: operand 0x80000010, count 5 → result 0xFC000000, carry 1, zero 0.
  - Same inputs with SHR → result 0x04000000, carry 1.
- SHL chain:
  - Operand 0x00000001, count 31 → result 0x80000000, carry 0.
  - Then operand 0x80000000, count 1 → result 0x00000000, carry 1, zero 1.
- Zero count and pass mode:
  - ROR 0x12345678, count 0 → `done` one cycle after the start edge, result 0x12345678, carry 0, `busy` never high.
  - Mode 110 with count 7 gives the same result.
- Reset mid-operation: ROL 0x0000FFFF, count 20; assert `clr` between edges k+3 and k+4:
  - `busy`, `done`, `result`, `carry` and `zero` drop to 0 immediately, with no `done` pulse.
  - After release, ROR 0x00000001, count 1 → result 0x80000000, carry 1.
- Handshake robustness: hold `start` high continuously while issuing ROL 0x00000003, count 2:
  - Changes to operand/count during RUN are ignored; result is 0x0000000C.
  - `start` during DONE is ignored.
  - The next operation is accepted from IDLE, with `done` pulses spaced exactly m+2 cycles apart.
